// File: rtl/button_input_conditioner.sv
// button_input_conditioner: synchronise, debounce and edge-detect push switches, with chord detect and optional auto-repeat
// Ports: i_Clk/i_Reset (sync, active-high); i_Buttons raw switches (1 = pressed);
//   o_Level debounced level; o_Press press/repeat pulse; o_Release release pulse;
//   o_Chord chord level; o_Chord_Pulse one-cycle pulse when o_Chord rises.
// Define INPUT_AUTO_REPEAT_EN to build the hold-to-repeat timers; otherwise o_Press fires once per press.
module button_input_conditioner #(
  parameter int NUM_BUTTONS = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_PERIOD = 2500000,
  parameter logic [NUM_BUTTONS-1:0] CHORD_MASK = {NUM_BUTTONS{1'b1}}
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic [NUM_BUTTONS-1:0] i_Buttons,
  output logic [NUM_BUTTONS-1:0] o_Level,
  output logic [NUM_BUTTONS-1:0] o_Press,
  output logic [NUM_BUTTONS-1:0] o_Release,
  output logic                   o_Chord,
  output logic                   o_Chord_Pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef INPUT_AUTO_REPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW = RMAX > 1 ? $clog2(RMAX) : 1;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
`else
  typedef enum logic {IDLE, HELD} state_t;
`endif
  logic [NUM_BUTTONS-1:0] level_nxt, press_raw, release_raw;
  logic chord_nxt;
  if (NUM_BUTTONS < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("button_input_conditioner: all size/delay parameters must be >= 1");
  end
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    logic s1, s2, hit, rise, fall, p, r;
    logic [CW-1:0] cnt;
    state_t st, st_nxt;
    // hit marks the last of DEBOUNCE_CYCLES consecutive mismatches: the level flips on this edge
    assign hit = (s2 != o_Level[i]) && cnt == CW'(DEBOUNCE_CYCLES - 1);
    assign level_nxt[i] = o_Level[i] ^ hit;
    assign rise = hit & ~o_Level[i];
    assign fall = hit & o_Level[i];
    assign press_raw[i] = p;
    assign release_raw[i] = r;
    always_ff @(posedge i_Clk)
      if (i_Reset) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
        cnt <= '0;
        st <= IDLE;
      end else begin
        s1 <= i_Buttons[i];
        s2 <= s1;
        cnt <= (s2 == o_Level[i] || hit) ? '0 : cnt + 1'b1;
        st <= st_nxt;
      end
`ifdef INPUT_AUTO_REPEAT_EN
    logic [TW-1:0] tmr, tmr_nxt;
    always_ff @(posedge i_Clk) tmr <= i_Reset ? '0 : tmr_nxt;
    always_comb begin
      st_nxt = st;
      tmr_nxt = '0;
      p = 1'b0;
      r = fall;
      if (fall) st_nxt = IDLE;
      else if (st == IDLE) begin
        p = rise;
        st_nxt = rise ? DELAY : IDLE;
      end else if (st == DELAY) begin
        p = tmr == TW'(REPEAT_DELAY - 1);
        st_nxt = p ? REPEAT : DELAY;
        tmr_nxt = p ? '0 : tmr + 1'b1;
      end else begin
        p = tmr == TW'(REPEAT_PERIOD - 1);
        tmr_nxt = p ? '0 : tmr + 1'b1;
      end
    end
`else
    always_comb begin
      st_nxt = rise ? HELD : (fall ? IDLE : st);
      p = rise;
      r = fall;
    end
`endif
  end
  assign chord_nxt = CHORD_MASK != '0 && (level_nxt & CHORD_MASK) == CHORD_MASK;
  // chord membership silences presses of its channels, including the completing one
  always_ff @(posedge i_Clk)
    if (i_Reset) begin
      o_Level <= '0;
      o_Press <= '0;
      o_Release <= '0;
      o_Chord <= 1'b0;
      o_Chord_Pulse <= 1'b0;
    end else begin
      o_Level <= level_nxt;
      o_Press <= press_raw & ~(CHORD_MASK & {NUM_BUTTONS{chord_nxt}});
      o_Release <= release_raw;
      o_Chord <= chord_nxt;
      o_Chord_Pulse <= chord_nxt & ~o_Chord;
    end
endmodule
